// File: rtl/npu_pkg.sv
// Shared NPU definitions: FSM/load-phase encodings, Q16.16 format and
// fixed-point helpers.
package npu_pkg;

  localparam int unsigned MAX_N     = 8;
  localparam int unsigned FRAC_BITS = 16;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StDone
  } npu_state_e;

  typedef enum logic [1:0] {
    PhCfg,
    PhWgt,
    PhIn
  } load_phase_e;

  typedef enum logic {
    ActIdentity = 1'b0,
    ActRelu     = 1'b1
  } act_e;

  // Full 64-bit signed product, rescaled and truncated back to Q16.16.
  function automatic logic [DATA_W-1:0] q_mul(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    prod = 64'($signed(a)) * 64'($signed(b));
    return DATA_W'(prod >>> FRAC_BITS);
  endfunction

  function automatic logic [DATA_W-1:0] apply_act(input logic [DATA_W-1:0] v,
                                                  input act_e act);
    return ((act == ActRelu) && v[DATA_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/npu_mac_lane.sv
// One destination-neuron lane: Q16.16 multiply-accumulate with a
// load-on-first-term clear and a bias add.
module npu_mac_lane
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mac_en,
  input  logic              i_first,
  input  logic              i_bias_en,
  input  logic [DATA_W-1:0] i_src,
  input  logic [DATA_W-1:0] i_wgt,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_d;

  always_comb begin
    w_acc_d = r_acc;
    if (i_mac_en) begin
      w_acc_d = (i_first ? '0 : r_acc) + q_mul(i_src, i_wgt);
    end else if (i_bias_en) begin
      w_acc_d = r_acc + i_wgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_d;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/npu.sv
// NPU top: host load/readback over a shared tri-state bus and a
// layer-sequential array of MAX_N MAC lanes.
module npu
  import npu_pkg::*;
#(
  parameter int unsigned MAX_N = npu_pkg::MAX_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              oe,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready
);

  localparam int unsigned IdxW   = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int unsigned KW     = $clog2(MAX_N + 2);
  localparam int unsigned WDepth = 3 * MAX_N * (MAX_N + 1);
  localparam int unsigned AW     = $clog2(WDepth);

  npu_state_e  r_state, w_state_d;
  load_phase_e r_phase;
  logic        r_we_q;
  logic [2:0]  r_cfg_idx;
  logic [1:0]  r_num_layers;
  logic [IdxW-1:0] r_n_in, r_n_h1, r_n_h2, r_n_out;
  act_e        r_act;

  logic [1:0]      r_wl;
  logic [IdxW-1:0] r_wd;
  logic [KW-1:0]   r_ws;
  logic [IdxW-1:0] r_in_idx;
  logic [1:0]      r_layer;
  logic [KW-1:0]   r_k;
  logic [IdxW-1:0] r_rd_ptr;

  logic [DATA_W-1:0] r_val  [MAX_N];
  logic [DATA_W-1:0] r_wram [WDepth];

  logic              w_start, w_word, w_last_in, w_last_layer;
  logic              w_mac, w_bias, w_wb, w_drive;
  logic [IdxW-1:0]   w_dim [4];
  logic [IdxW-1:0]   w_cp_dst;
  logic [KW-1:0]     w_cp_src, w_ld_bias, w_kidx;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr  [MAX_N];
  logic [DATA_W-1:0] w_lane_wgt [MAX_N];
  logic [DATA_W-1:0] w_acc      [MAX_N];
  logic [DATA_W-1:0] w_src_val, w_dout;

  // Weights are stored per (weight layer, destination lane, source/bias slot).
  function automatic logic [AW-1:0] wram_addr(input logic [1:0] l, input logic [IdxW-1:0] j,
                                               input logic [KW-1:0] k);
    return AW'((32'(l) * MAX_N + 32'(j)) * (MAX_N + 1) + 32'(k));
  endfunction

  // Neuron count minus one of each position in the layer chain.
  assign w_dim[0] = r_n_in;
  assign w_dim[1] = (r_num_layers >= 2'd1) ? r_n_h1 : r_n_out;
  assign w_dim[2] = (r_num_layers == 2'd2) ? r_n_h2 : r_n_out;
  assign w_dim[3] = r_n_out;

  assign w_start   = we & ~r_we_q;
  assign w_word    = we & r_we_q & (r_state == StLoad);
  assign w_last_in = (r_phase == PhIn) && (r_in_idx == r_n_in);
  assign w_ld_bias = KW'(w_dim[r_wl]) + KW'(1);
  assign w_wr_addr = wram_addr(r_wl, r_wd, r_ws);

  assign w_cp_src     = KW'(w_dim[r_layer]);
  assign w_cp_dst     = w_dim[r_layer + 2'd1];
  assign w_last_layer = (r_layer == r_num_layers);
  assign w_mac  = (r_state == StCompute) && (r_k <= w_cp_src);
  assign w_bias = (r_state == StCompute) && (r_k == w_cp_src + KW'(1));
  assign w_wb   = (r_state == StCompute) && (r_k == w_cp_src + KW'(2));
  assign w_kidx    = (r_k > KW'(MAX_N)) ? KW'(MAX_N) : r_k;
  assign w_src_val = r_val[IdxW'(r_k)];

  always_comb begin
    w_state_d = r_state;
    if (w_start) begin
      w_state_d = StLoad;
    end else begin
      case (r_state)
        StLoad:    if (w_word && w_last_in) w_state_d = StCompute;
        StCompute: if (w_wb && w_last_layer) w_state_d = StDone;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_phase      <= PhCfg;
      r_we_q       <= 1'b0;
      r_cfg_idx    <= '0;
      r_num_layers <= '0;
      r_n_in       <= '0;
      r_n_h1       <= '0;
      r_n_h2       <= '0;
      r_n_out      <= '0;
      r_act        <= ActIdentity;
      r_wl         <= '0;
      r_wd         <= '0;
      r_ws         <= '0;
      r_in_idx     <= '0;
      r_layer      <= '0;
      r_k          <= '0;
      r_rd_ptr     <= '0;
      r_val        <= '{default: '0};
    end else begin
      r_state <= w_state_d;
      r_we_q  <= we;
      if (w_start) begin
        r_phase   <= PhCfg;
        r_cfg_idx <= '0;
        r_wl      <= '0;
        r_wd      <= '0;
        r_ws      <= '0;
        r_in_idx  <= '0;
        r_layer   <= '0;
        r_k       <= '0;
        r_rd_ptr  <= '0;
      end else begin
        if (oe) begin
          r_rd_ptr <= (r_rd_ptr == r_n_out) ? '0 : r_rd_ptr + 1'b1;
        end
        if (w_word) begin
          case (r_phase)
            PhCfg: begin
              r_cfg_idx <= r_cfg_idx + 3'd1;
              case (r_cfg_idx)
                3'd0:    r_num_layers <= (data[1:0] == 2'd3) ? 2'd2 : data[1:0];
                3'd1:    r_n_in  <= data[IdxW-1:0];
                3'd2:    r_n_h1  <= data[IdxW-1:0];
                3'd3:    r_n_h2  <= data[IdxW-1:0];
                3'd4:    r_n_out <= data[IdxW-1:0];
                default: begin
                  r_act   <= act_e'(data[0]);
                  r_phase <= PhWgt;
                end
              endcase
            end
            PhWgt: begin
              if (r_ws == w_ld_bias) begin
                r_ws <= '0;
                if (r_wd == w_dim[r_wl + 2'd1]) begin
                  r_wd <= '0;
                  if (r_wl == r_num_layers) r_phase <= PhIn;
                  else r_wl <= r_wl + 2'd1;
                end else begin
                  r_wd <= r_wd + 1'b1;
                end
              end else begin
                r_ws <= r_ws + KW'(1);
              end
            end
            default: begin
              r_val[r_in_idx] <= data;
              r_in_idx        <= r_in_idx + 1'b1;
            end
          endcase
        end
        if (r_state == StCompute) begin
          if (w_wb) begin
            for (int unsigned j = 0; j < MAX_N; j++) begin
              if (IdxW'(j) <= w_cp_dst) r_val[j] <= apply_act(w_acc[j], r_act);
            end
            r_k     <= '0;
            r_layer <= r_layer + 2'd1;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
      end
    end
  end

  // Weight RAM is not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_word && (r_phase == PhWgt)) begin
      r_wram[w_wr_addr] <= data;
    end
  end

  for (genvar g = 0; g < MAX_N; g++) begin : g_lane
    assign w_rd_addr[g]  = wram_addr(r_layer, IdxW'(g), w_kidx);
    assign w_lane_wgt[g] = r_wram[w_rd_addr[g]];

    npu_mac_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_mac_en  (w_mac),
      .i_first   (r_k == '0),
      .i_bias_en (w_bias),
      .i_src     (w_src_val),
      .i_wgt     (w_lane_wgt[g]),
      .o_acc     (w_acc[g])
    );
  end

  assign ready   = (r_state == StDone);
  assign w_drive = oe & ~we & ~rst;
  assign w_dout  = ready ? r_val[r_rd_ptr] : '0;
  assign data    = w_drive ? w_dout : {DATA_W{1'bz}};

endmodule

// File: tb/tb_npu.sv
// Directed bench for npu: small networks with hand-computed Q16.16 results,
// back-to-back loads, mid-load reset and bus tri-state behaviour.
module tb_npu;

  logic        clk = 1'b0;
  logic        rst, we, oe, tb_en;
  logic [31:0] tb_drv;
  logic        ready;
  tri1  [31:0] data;  // pulled up so an undriven bus reads all ones

  localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] vec[$];

  assign data = tb_en ? tb_drv : 'z;

  always #5 clk = ~clk;

  npu #(.MAX_N(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .oe    (oe),
    .data  (data),
    .ready (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    we = 1'b1; tb_en = 1'b1; tb_drv = w;
    tick();
  endtask

  // Start edge (data ignored), then every word of vec.
  task automatic load_vec(input string tag);
    send(32'hDEAD_BEEF);
    check({tag, "_ready_at_start"}, {31'b0, ready}, 32'd0);
    foreach (vec[i]) send(vec[i]);
    we = 1'b0; tb_en = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    for (int i = 0; i < budget && !ready; i++) tick();
    check(tag, {31'b0, ready}, 32'd1);
  endtask

  // One read; oe is left high so successive calls hold it across edges.
  task automatic rd(input string tag, input logic [31:0] exp);
    oe = 1'b1;
    #1;
    check(tag, data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = 1'b0; oe = 1'b0; tb_en = 1'b0; tb_drv = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_z", data, ZBUS);
    oe = 1'b1; #1;
    check("rst_oe_zero", data, 32'h0);
    oe = 1'b0; #1;

    // 1-in/2-out, identity: 2*3+1 = 7, -1*3+0.5 = -2.5
    vec = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0,
            32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000,
            32'h0003_0000};
    load_vec("t1");
    oe = 1'b1; #1;
    check("t1_oe_busy", data, 32'h0);
    oe = 1'b0; #1;
    check("t1_z_busy", data, ZBUS);
    repeat (5) tick();
    check("t1_ready_5cyc", {31'b0, ready}, 32'd1);
    check("t1_z_done", data, ZBUS);
    rd("t1_out0", 32'h0007_0000);
    rd("t1_out1", 32'hFFFD_8000);
    rd("t1_wrap", 32'h0007_0000);
    oe = 1'b0;

    // Same network with ReLU, loaded straight after the previous one.
    vec[5] = 32'd1;
    load_vec("t2");
    wait_ready("t2_ready", 20);
    rd("t2_out0", 32'h0007_0000);
    rd("t2_out1", 32'h0000_0000);
    oe = 1'b0;

    // Back-to-back, identity, input 1.0: 3.0 and -0.5
    vec[5]  = 32'd0;
    vec[10] = 32'h0001_0000;
    load_vec("t3");
    wait_ready("t3_ready", 20);
    rd("t3_out0", 32'h0003_0000);
    rd("t3_out1", 32'hFFFF_8000);
    oe = 1'b0;

    // Reset in the middle of the weight words.
    send(32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) send(vec[i]);
    rst = 1'b1;
    tick();
    we = 1'b0; tb_en = 1'b0; oe = 1'b1; #1;
    check("t4_z_in_rst", data, ZBUS);
    check("t4_ready_in_rst", {31'b0, ready}, 32'd0);
    tick();
    rst = 1'b0; oe = 1'b0; #1;
    check("t4_ready_after", {31'b0, ready}, 32'd0);
    check("t4_z_after", data, ZBUS);
    // Full reload, input 2.0: 5.0 and -1.5
    vec[10] = 32'h0002_0000;
    load_vec("t4");
    wait_ready("t4_ready", 20);
    rd("t4_out0", 32'h0005_0000);
    rd("t4_out1", 32'hFFFE_8000);
    oe = 1'b0;

    // 2-2-1 ReLU (H2 count ignored). h0 = 0.5+2+0.25 = 2.75, h1 = 1-4 -> 0,
    // out = 2*2.75 + 3*0 - 1 = 4.5
    vec = '{32'd1, 32'd1, 32'd1, 32'd5, 32'd0, 32'd1,
            32'h0000_8000, 32'h0001_0000, 32'h0000_4000,
            32'h0001_0000, 32'hFFFE_0000, 32'h0000_0000,
            32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000,
            32'h0001_0000, 32'h0002_0000};
    load_vec("t5");
    wait_ready("t5_ready", 20);
    rd("t5_out_a", 32'h0004_8000);
    rd("t5_out_b", 32'h0004_8000);
    rd("t5_out_c", 32'h0004_8000);
    oe = 1'b0;

    // NUM_LAYERS=3 acts as 2: 1 -> 2 -> 1.5*2+0.25 = 3.25 -> -3.25+1 = -2.25
    vec = '{32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
            32'h0002_0000, 32'h0000_0000,
            32'h0001_8000, 32'h0000_4000,
            32'hFFFF_0000, 32'h0001_0000,
            32'h0001_0000};
    load_vec("t6");
    wait_ready("t6_ready", 30);
    rd("t6_out0", 32'hFFFD_C000);
    oe = 1'b0; #1;
    check("t6_z_end", data, ZBUS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
